adc_conditioner: RTL and testbench
==================================

ADC_CONDITIONER -- requirements
Module: adc_conditioner

Interface
REQ-001 SHALL have parameter ADC_BITS, default 16, ADC sample width.
REQ-002 SHALL have parameter DC_SHIFT, default 16, DC-blocker leak shift (corner about fs/2^DC_SHIFT/2pi).
REQ-003 SHALL have parameter OVL_HOLD, default 48000, overload indication hold time in clk_in cycles.
REQ-004 SHALL have port clk_in, input, 1, sample clock; the block has one clock.
REQ-005 SHALL have port reset_in, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port ADC_IN, input, ADC_BITS, raw ADC code in offset-binary, possibly randomized.
REQ-007 SHALL have port ADC_OVR, input, 1, ADC overrange pin.
REQ-008 SHALL have port RAND_EN, input, 1, derandomizer enable.
REQ-009 SHALL have port DC_EN, input, 1, DC-blocker enable.
REQ-010 SHALL have port OVL_CLEAR, input, 1, clear pulse for OVL_COUNT.
REQ-011 SHALL have port DATA_OUT, output, ADC_BITS, signed two's-complement sample.
REQ-012 SHALL have port DATA_VALID, output, 1, DATA_OUT holds pipeline-filled data.
REQ-013 SHALL have port OVERLOAD, output, 1, stretched overload flag.
REQ-014 SHALL have port OVL_COUNT, output, 16, saturating overload-sample counter.

Function
REQ-015 SHALL use stage 1 to register ADC_IN and ADC_OVR.
REQ-016 SHALL use stage 2 to derandomize when RAND_EN=1: bits [ADC_BITS-1:1] XOR bit 0, bit 0 unchanged; RAND_EN=0 passes the code through.
REQ-017 SHALL use stage 2 to convert to signed by inverting the MSB (0x0000->-32768, 0x8000->0, 0xFFFF->32767), then register.
REQ-018 SHALL flag a stage-2 overload event when the registered ADC_OVR=1 or the derandomized code is all-zeros or all-ones.
REQ-019 SHALL, in stage 3 with DC_EN=1, compute dc = acc >>> DC_SHIFT, y = x - dc (ADC_BITS+1 bits), acc <= acc + y, where acc is signed ADC_BITS+DC_SHIFT+1 bits.
REQ-020 SHALL saturate y to [-2^(ADC_BITS-1), 2^(ADC_BITS-1)-1] before registering it to DATA_OUT; acc update uses unsaturated y.
REQ-021 SHALL, with DC_EN=0, set DATA_OUT = x and hold acc at 0; a 0->1 transition restarts from acc=0.
REQ-022 SHALL give a latency of exactly 3 clk_in cycles from ADC_IN sampling edge to DATA_OUT.
REQ-023 SHALL hold DATA_VALID low for the first 3 cycles after reset release, then high continuously.
REQ-024 SHALL assert OVERLOAD in the same cycle DATA_OUT carries the offending sample, reload a hold counter to OVL_HOLD-1, and decrement it each cycle.
REQ-025 SHALL deassert OVERLOAD when the hold counter is 0 and no new event occurs; each new event retriggers the full hold.
REQ-026 SHALL increment OVL_COUNT by 1 per overload sample, aligned with OVERLOAD, saturating at 0xFFFF.
REQ-027 SHALL, on OVL_CLEAR, set OVL_COUNT to 0, or to 1 if an event occurs in the same cycle; OVERLOAD is unaffected.

Reset
REQ-028 SHALL clear all pipeline registers, acc, and the hold counter, and set DATA_OUT=0, DATA_VALID=0, OVERLOAD=0, OVL_COUNT=0, while reset_in=1 at a clk_in edge.
REQ-029 SHALL discard in-flight samples on reset mid-stream and refill the pipeline per REQ-023.

Structure
REQ-030 SHALL place ADC_BITS default, counter width 16, and the saturation limits in shared package adc_cond_pkg.
REQ-031 SHALL implement the DC blocker (REQ-019..021) as sub-module adc_dc_blocker.

Verification
REQ-032 SHALL verify with ADC_IN=0x8000, RAND_EN=0, DC_EN=0 that DATA_OUT=0x0000 after 3 cycles, with DATA_VALID rising on cycle 4.
REQ-033 SHALL verify with RAND_EN=1, ADC_IN=0x0003 that DATA_OUT=0x7FFD (derandomized 0xFFFD, MSB inverted).
REQ-034 SHALL verify with DC_EN=1, constant ADC_IN=0x9000 (x=+4096) that DATA_OUT decays monotonically toward 0, with |DATA_OUT|<=1 after 20*2^DC_SHIFT cycles.
REQ-035 SHALL verify that a single ADC_IN=0xFFFF sample asserts OVERLOAD with that sample for exactly OVL_HOLD cycles and sets OVL_COUNT=1; a second event mid-hold extends it.
REQ-036 SHALL verify that OVL_CLEAR in the same cycle as an overload event with OVL_COUNT=5 gives OVL_COUNT=1.
REQ-037 SHALL verify that 70000 consecutive ADC_OVR=1 samples saturate OVL_COUNT at 0xFFFF.

Source files
------------

// File: rtl/adc_cond_pkg.sv
// Shared constants and helpers for the ADC conditioning pipeline.
// Holds the default sample width, the overload counter width and the saturation limits.
package adc_cond_pkg;

  localparam int unsigned ADC_BITS_DEF = 16;
  localparam int unsigned CNT_W        = 16;

  typedef logic [CNT_W-1:0] ovl_cnt_t;

  localparam ovl_cnt_t CNT_MAX = '1;

  // Largest positive two's-complement value for a given width.
  function automatic int sat_max(input int unsigned bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  // Most negative two's-complement value for a given width.
  function automatic int sat_min(input int unsigned bits);
    return -(1 << (bits - 1));
  endfunction

endpackage

// File: rtl/adc_dc_blocker.sv
// Leaky-integrator DC blocker: y = x - (acc >>> DC_SHIFT), acc += y, y saturated on output.
// When disabled the sample passes straight through and the integrator is held at zero.
module adc_dc_blocker
  import adc_cond_pkg::*;
#(
  parameter int unsigned ADC_BITS = ADC_BITS_DEF,
  parameter int unsigned DC_SHIFT = 16
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic                i_en,
  input  logic [ADC_BITS-1:0] i_x,
  output logic [ADC_BITS-1:0] o_y
);

  localparam int unsigned YW   = ADC_BITS + 1;
  localparam int unsigned AccW = ADC_BITS + DC_SHIFT + 1;

  localparam logic signed [YW-1:0] YMax = YW'(sat_max(ADC_BITS));
  localparam logic signed [YW-1:0] YMin = YW'(sat_min(ADC_BITS));

  logic signed [AccW-1:0]     r_acc;
  logic        [ADC_BITS-1:0] r_y;

  logic signed [YW-1:0]       w_x_ext;
  logic signed [YW-1:0]       w_dc;
  logic signed [YW-1:0]       w_y;
  logic signed [AccW-1:0]     w_y_ext;
  logic        [ADC_BITS-1:0] w_y_sat;

  always_comb begin
    w_x_ext = {i_x[ADC_BITS-1], i_x};
    // The shifted accumulator always fits in YW bits, so the narrowing is lossless.
    w_dc    = YW'(r_acc >>> DC_SHIFT);
    w_y     = w_x_ext - w_dc;
    w_y_ext = {{DC_SHIFT{w_y[YW-1]}}, w_y};
    if (w_y > YMax) begin
      w_y_sat = YMax[ADC_BITS-1:0];
    end else if (w_y < YMin) begin
      w_y_sat = YMin[ADC_BITS-1:0];
    end else begin
      w_y_sat = w_y[ADC_BITS-1:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_acc <= '0;
      r_y   <= '0;
    end else if (!i_en) begin
      r_acc <= '0;
      r_y   <= i_x;
    end else begin
      // The integrator tracks the unsaturated difference so it keeps converging.
      r_acc <= r_acc + w_y_ext;
      r_y   <= w_y_sat;
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/adc_conditioner.sv
// Three-stage ADC front end: capture, derandomize/convert to signed, DC block.
// Also produces a stretched overload flag and a saturating overload-sample counter.
module adc_conditioner
  import adc_cond_pkg::*;
#(
  parameter int unsigned ADC_BITS = ADC_BITS_DEF,
  parameter int unsigned DC_SHIFT = 16,
  parameter int unsigned OVL_HOLD = 48000
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic [ADC_BITS-1:0] ADC_IN,
  input  logic                ADC_OVR,
  input  logic                RAND_EN,
  input  logic                DC_EN,
  input  logic                OVL_CLEAR,
  output logic [ADC_BITS-1:0] DATA_OUT,
  output logic                DATA_VALID,
  output logic                OVERLOAD,
  output logic [CNT_W-1:0]    OVL_COUNT
);

  localparam int unsigned        HoldW    = $clog2(OVL_HOLD + 1);
  localparam logic [HoldW-1:0]   HoldLoad = HoldW'(OVL_HOLD - 1);

  logic [ADC_BITS-1:0] r_s1_code;
  logic                r_s1_ovr;
  logic [ADC_BITS-1:0] r_s2_x;
  logic                r_s2_evt;
  // One bit per stage: set once that stage holds a sample taken after reset.
  logic [2:0]          r_fill;
  logic                r_ovl;
  logic [HoldW-1:0]    r_hold;
  ovl_cnt_t            r_cnt;

  logic [ADC_BITS-1:0] w_derand;
  logic [ADC_BITS-1:0] w_x;
  logic                w_evt;
  logic                w_ovl_d;
  logic [HoldW-1:0]    w_hold_d;
  ovl_cnt_t            w_cnt_d;

  // Stage 2: derandomize, flag rail codes, flip MSB to go offset-binary -> two's complement.
  always_comb begin
    w_derand = r_s1_code;
    if (RAND_EN) begin
      w_derand = {r_s1_code[ADC_BITS-1:1] ^ {(ADC_BITS-1){r_s1_code[0]}}, r_s1_code[0]};
    end
    w_x   = {~w_derand[ADC_BITS-1], w_derand[ADC_BITS-2:0]};
    w_evt = r_s1_ovr | (w_derand == '0) | (&w_derand);
  end

  // Overload hold and counter next state, aligned with the sample entering DATA_OUT.
  always_comb begin
    w_ovl_d  = r_s2_evt | (r_hold != '0);
    w_hold_d = r_hold;
    if (r_s2_evt) begin
      w_hold_d = HoldLoad;
    end else if (r_hold != '0) begin
      w_hold_d = r_hold - 1'b1;
    end

    w_cnt_d = r_cnt;
    if (OVL_CLEAR) begin
      w_cnt_d = r_s2_evt ? ovl_cnt_t'(1) : '0;
    end else if (r_s2_evt && (r_cnt != CNT_MAX)) begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_s1_code <= '0;
      r_s1_ovr  <= 1'b0;
      r_s2_x    <= '0;
      r_s2_evt  <= 1'b0;
      r_fill    <= '0;
      r_ovl     <= 1'b0;
      r_hold    <= '0;
      r_cnt     <= '0;
    end else begin
      r_s1_code <= ADC_IN;
      r_s1_ovr  <= ADC_OVR;
      // Cleared stage-1 contents are not a sample: keep them out of data and events.
      r_s2_x    <= r_fill[0] ? w_x : '0;
      r_s2_evt  <= r_fill[0] & w_evt;
      r_fill    <= {r_fill[1:0], 1'b1};
      r_ovl     <= w_ovl_d;
      r_hold    <= w_hold_d;
      r_cnt     <= w_cnt_d;
    end
  end

  adc_dc_blocker #(
    .ADC_BITS (ADC_BITS),
    .DC_SHIFT (DC_SHIFT)
  ) u_dc_blocker (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .i_en     (DC_EN),
    .i_x      (r_s2_x),
    .o_y      (DATA_OUT)
  );

  assign DATA_VALID = r_fill[2];
  assign OVERLOAD   = r_ovl;
  assign OVL_COUNT  = r_cnt;

endmodule

// File: tb/tb_adc_conditioner.sv
// Directed bench for adc_conditioner with a short DC corner and hold time.
// Expected values are hand-computed for ADC_BITS=16, DC_SHIFT=4, OVL_HOLD=8.
module tb_adc_conditioner;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [15:0] ADC_IN;
  logic        ADC_OVR;
  logic        RAND_EN;
  logic        DC_EN;
  logic        OVL_CLEAR;
  logic [15:0] DATA_OUT;
  logic        DATA_VALID;
  logic        OVERLOAD;
  logic [15:0] OVL_COUNT;

  int n_vec = 0;
  int n_err = 0;
  int hi;
  int mono_bad;
  logic signed [15:0] cur;
  logic signed [15:0] prev;

  adc_conditioner #(
    .ADC_BITS (16),
    .DC_SHIFT (4),
    .OVL_HOLD (8)
  ) dut (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .ADC_IN     (ADC_IN),
    .ADC_OVR    (ADC_OVR),
    .RAND_EN    (RAND_EN),
    .DC_EN      (DC_EN),
    .OVL_CLEAR  (OVL_CLEAR),
    .DATA_OUT   (DATA_OUT),
    .DATA_VALID (DATA_VALID),
    .OVERLOAD   (OVERLOAD),
    .OVL_COUNT  (OVL_COUNT)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated sample at the input; returns right after it reaches DATA_OUT.
  task automatic pulse_sample(input logic [15:0] code);
    ADC_IN = code;
    step();
    ADC_IN = 16'h8000;
    step();
    step();
  endtask

  initial begin
    reset_in  = 1'b1;
    ADC_IN    = 16'h8000;
    ADC_OVR   = 1'b0;
    RAND_EN   = 1'b0;
    DC_EN     = 1'b0;
    OVL_CLEAR = 1'b0;
    steps(2);
    chk("rst_data", DATA_OUT, 16'h0000);
    chk("rst_valid", DATA_VALID, 1'b0);
    chk("rst_ovl", OVERLOAD, 1'b0);
    chk("rst_cnt", OVL_COUNT, 16'h0000);

    // Fill after reset release: valid appears with the first real sample.
    reset_in = 1'b0;
    step();
    chk("fill1_valid", DATA_VALID, 1'b0);
    step();
    chk("fill2_valid", DATA_VALID, 1'b0);
    step();
    chk("fill3_valid", DATA_VALID, 1'b1);
    chk("fill3_data", DATA_OUT, 16'h0000);

    // Streaming latency with distinct consecutive codes.
    ADC_IN = 16'h9000; step();
    ADC_IN = 16'h7000; step();
    chk("lat_early", DATA_OUT, 16'h0000);
    ADC_IN = 16'hC000; step();
    chk("lat_v0", DATA_OUT, 16'h1000);
    ADC_IN = 16'h8000; step();
    chk("lat_v1", DATA_OUT, 16'hF000);
    step();
    chk("lat_v2", DATA_OUT, 16'h4000);
    chk("lat_valid", DATA_VALID, 1'b1);

    // Derandomizer.
    RAND_EN = 1'b1; ADC_IN = 16'h0003; steps(3);
    chk("rand_0003", DATA_OUT, 16'h7FFD);
    chk("rand_0003_ovl", OVERLOAD, 1'b0);
    ADC_IN = 16'h1234; steps(3);
    chk("rand_1234", DATA_OUT, 16'h9234);
    RAND_EN = 1'b0; ADC_IN = 16'h0003; steps(3);
    chk("norand_0003", DATA_OUT, 16'h8003);
    ADC_IN = 16'h8000; steps(3);

    // Single overload sample: aligned with data, held exactly 8 cycles.
    ADC_IN = 16'hFFFF; step();
    ADC_IN = 16'h8000; step();
    chk("ovl_not_early", OVERLOAD, 1'b0);
    step();
    chk("ovl_aligned", OVERLOAD, 1'b1);
    chk("ovl_data", DATA_OUT, 16'h7FFF);
    chk("ovl_cnt1", OVL_COUNT, 16'h0001);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (OVERLOAD !== 1'b1) break;
      hi++;
      step();
    end
    chk("ovl_hold_len", hi, 8);

    // Retrigger three cycles into the hold.
    pulse_sample(16'hFFFF);
    ADC_IN = 16'hFFFF; step();
    chk("retrig_mid1", OVERLOAD, 1'b1);
    ADC_IN = 16'h8000; step();
    chk("retrig_mid2", OVERLOAD, 1'b1);
    step();
    chk("retrig_cnt", OVL_COUNT, 16'h0003);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (OVERLOAD !== 1'b1) break;
      hi++;
      step();
    end
    chk("retrig_hold_len", hi, 8);

    // Clear coinciding with an event.
    pulse_sample(16'hFFFF);
    pulse_sample(16'h0000);
    chk("cnt5", OVL_COUNT, 16'h0005);
    ADC_IN = 16'hFFFF; step();
    ADC_IN = 16'h8000; step();
    OVL_CLEAR = 1'b1; step();
    OVL_CLEAR = 1'b0;
    chk("clr_with_evt", OVL_COUNT, 16'h0001);
    OVL_CLEAR = 1'b1; step();
    OVL_CLEAR = 1'b0;
    chk("clr_plain", OVL_COUNT, 16'h0000);
    chk("clr_keeps_ovl", OVERLOAD, 1'b1);

    // Rail code produced by the derandomizer counts as overload.
    RAND_EN = 1'b1; ADC_IN = 16'h0001; steps(3);
    chk("rand_rail_data", DATA_OUT, 16'h7FFF);
    chk("rand_rail_cnt", OVL_COUNT, 16'h0001);
    RAND_EN = 1'b0; ADC_IN = 16'h8000;

    // Counter saturation from the overrange pin.
    ADC_OVR = 1'b1;
    steps(70000);
    ADC_OVR = 1'b0;
    steps(3);
    chk("cnt_sat", OVL_COUNT, 16'hFFFF);
    chk("ovr_pin_ovl", OVERLOAD, 1'b1);
    chk("ovr_data", DATA_OUT, 16'h0000);

    // Reset mid-stream discards the in-flight rail sample.
    ADC_IN = 16'hFFFF; step();
    reset_in = 1'b1; ADC_IN = 16'h9000; step();
    chk("mrst_data", DATA_OUT, 16'h0000);
    chk("mrst_valid", DATA_VALID, 1'b0);
    chk("mrst_ovl", OVERLOAD, 1'b0);
    chk("mrst_cnt", OVL_COUNT, 16'h0000);
    reset_in = 1'b0;
    step();
    chk("mrst_fill1", DATA_VALID, 1'b0);
    step();
    chk("mrst_fill2", DATA_VALID, 1'b0);
    chk("mrst_fill2_data", DATA_OUT, 16'h0000);
    step();
    chk("mrst_fill3", DATA_VALID, 1'b1);
    chk("mrst_fill3_data", DATA_OUT, 16'h1000);
    chk("mrst_no_ovl", OVERLOAD, 1'b0);

    // DC blocker on x=+4096: 4096, 3840, 3600, then decay to zero.
    DC_EN = 1'b1; step();
    chk("dc_y0", DATA_OUT, 16'h1000);
    step();
    chk("dc_y1", DATA_OUT, 16'h0F00);
    step();
    chk("dc_y2", DATA_OUT, 16'h0E10);
    prev = DATA_OUT;
    cur = prev;
    mono_bad = 0;
    for (int i = 0; i < 320; i++) begin
      step();
      cur = DATA_OUT;
      if (cur > prev || cur < 0) mono_bad++;
      prev = cur;
    end
    chk("dc_monotonic", mono_bad, 0);
    chk("dc_settled", (cur <= 1 && cur >= -1), 1'b1);

    // Disable then re-enable restarts the integrator from zero.
    DC_EN = 1'b0; step();
    chk("dc_off_pass", DATA_OUT, 16'h1000);
    DC_EN = 1'b1; step();
    chk("dc_restart_y0", DATA_OUT, 16'h1000);
    step();
    chk("dc_restart_y1", DATA_OUT, 16'h0F00);

    // Negative saturation: settled dc=+4096, x=-32768 gives -36864.
    steps(320);
    ADC_IN = 16'h0000; steps(3);
    chk("dc_sat_neg", DATA_OUT, 16'h8000);

    // Positive saturation: settled dc=-4096, x=+32767 gives +36863.
    DC_EN = 1'b0; ADC_IN = 16'h7000; steps(3);
    chk("dc_off_neg", DATA_OUT, 16'hF000);
    DC_EN = 1'b1; steps(320);
    cur = DATA_OUT;
    chk("dc_settled_neg", (cur <= 1 && cur >= -1), 1'b1);
    ADC_IN = 16'hFFFF; steps(3);
    chk("dc_sat_pos", DATA_OUT, 16'h7FFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
